// File: rtl/prng_burst_scheduler_if.sv
// Client, generator and beat-output signals of the PRNG burst scheduler.
interface prng_burst_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    // Client side
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] seed_bus;
    logic [NUM_REQ-1:0]        gnt;

    // Generator side
    logic                      gen_in_valid;
    logic [DATA_W-1:0]         gen_seed;
    logic                      gen_busy;
    logic                      gen_out_valid;
    logic [DATA_W-1:0]         gen_rand;

    // Forwarded beats
    logic                      out_valid;
    logic [ID_W-1:0]           out_id;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic                      idle;

    // Scheduler view
    modport slave (
        input  req, seed_bus, gen_busy, gen_out_valid, gen_rand,
        output gnt, gen_in_valid, gen_seed, out_valid, out_id, out_data, out_last, idle
    );

    // Environment view (clients + generator + beat sink)
    modport master (
        output req, seed_bus, gen_busy, gen_out_valid, gen_rand,
        input  gnt, gen_in_valid, gen_seed, out_valid, out_id, out_data, out_last, idle
    );
endinterface

// File: rtl/prng_burst_scheduler.sv
// Round-robin scheduler sharing one PRNG generator among NUM_REQ requesters.
// Each grant loads one seed and forwards exactly BURST_LEN tagged beats.
module prng_burst_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned DATA_W    = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    prng_burst_scheduler_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

    state_e state_q, state_d;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gen_in_valid_q, gen_in_valid_d;
    logic [DATA_W-1:0]  gen_seed_q, gen_seed_d;
    logic               out_valid_q, out_valid_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               idle_q, idle_d;

    logic [DATA_W-1:0]  seeds [NUM_REQ];
    logic [ID_W-1:0]    scan_idx [NUM_REQ];
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic               last_beat;

    // Round-robin search: first active request at or after rr_ptr, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            seeds[i]    = bus.seed_bus[i*DATA_W +: DATA_W];
            scan_idx[i] = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && bus.req[scan_idx[i]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[i];
            end
        end
    end

    assign last_beat = bus.gen_out_valid && (cnt_q == LAST_CNT);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pick_found) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (last_beat) state_d = StDrain;
            StDrain: if (!bus.gen_busy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath next values; every output leaves through a flop
    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        gnt_d          = '0;
        gen_in_valid_d = 1'b0;
        gen_seed_d     = gen_seed_q;
        out_valid_d    = 1'b0;
        out_id_d       = out_id_q;
        out_data_d     = out_data_q;
        out_last_d     = 1'b0;
        idle_d         = (state_d == StIdle);
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    gen_in_valid_d  = 1'b1;
                    gen_seed_d      = seeds[pick_idx];
                    owner_d         = pick_idx;
                    rr_ptr_d        = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_W'(1);
                end
            end
            StLoad: cnt_d = '0;
            StRun: begin
                if (bus.gen_out_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.gen_rand;
                    out_id_d    = owner_q;
                    out_last_d  = last_beat;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            cnt_q          <= '0;
            gnt_q          <= '0;
            gen_in_valid_q <= 1'b0;
            gen_seed_q     <= '0;
            out_valid_q    <= 1'b0;
            out_id_q       <= '0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            idle_q         <= 1'b1;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            gnt_q          <= gnt_d;
            gen_in_valid_q <= gen_in_valid_d;
            gen_seed_q     <= gen_seed_d;
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            idle_q         <= idle_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.gen_in_valid = gen_in_valid_q;
    assign bus.gen_seed     = gen_seed_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_id       = out_id_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign bus.idle         = idle_q;
endmodule

// File: tb/tb_prng_burst_scheduler.sv
// Bench for prng_burst_scheduler: a BURST_LEN=256 instance and a BURST_LEN=1 instance
// share identical stimulus; the outputs of the one selected by sel are checked.
module tb_prng_burst_scheduler;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int MODE_ON   = 0;
    localparam int MODE_GAP  = 1;
    localparam int MODE_RAND = 2;

    logic clk;
    logic rst_n;

    prng_burst_scheduler_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus0 ();
    prng_burst_scheduler_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus1 ();

    prng_burst_scheduler #(.NUM_REQ(NREQ), .BURST_LEN(256), .DATA_W(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    prng_burst_scheduler #(.NUM_REQ(NREQ), .BURST_LEN(1), .DATA_W(DW)) u_dut_len1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus1.req           = bus0.req;
    assign bus1.seed_bus      = bus0.seed_bus;
    assign bus1.gen_busy      = bus0.gen_busy;
    assign bus1.gen_out_valid = bus0.gen_out_valid;
    assign bus1.gen_rand      = bus0.gen_rand;

    bit          sel;
    int          cur_len;
    int          model_rr;
    int          tests_run;
    int          tests_failed;

    logic [3:0]  o_gnt;
    logic        o_giv;
    logic [31:0] o_seed;
    logic        o_valid;
    logic [1:0]  o_id;
    logic [31:0] o_data;
    logic        o_last;
    logic        o_idle;

    assign o_gnt   = sel ? bus1.gnt          : bus0.gnt;
    assign o_giv   = sel ? bus1.gen_in_valid : bus0.gen_in_valid;
    assign o_seed  = sel ? bus1.gen_seed     : bus0.gen_seed;
    assign o_valid = sel ? bus1.out_valid    : bus0.out_valid;
    assign o_id    = sel ? bus1.out_id       : bus0.out_id;
    assign o_data  = sel ? bus1.out_data     : bus0.out_data;
    assign o_last  = sel ? bus1.out_last     : bus0.out_last;
    assign o_idle  = sel ? bus1.idle         : bus0.idle;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin rule: first requester at or after ptr, wrapping
    function automatic int rr_pick(input logic [3:0] m, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (m[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return 0;
    endfunction

    function automatic bit beat_on(input int mode, input int cyc);
        case (mode)
            MODE_ON:  return 1'b1;
            MODE_GAP: return (cyc % 8) < 3;
            default:  return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_gnt"},       o_gnt,   0);
        check_eq({tag, "_gen_valid"}, o_giv,   0);
        check_eq({tag, "_gen_seed"},  o_seed,  0);
        check_eq({tag, "_out_valid"}, o_valid, 0);
        check_eq({tag, "_out_id"},    o_id,    0);
        check_eq({tag, "_out_data"},  o_data,  0);
        check_eq({tag, "_out_last"},  o_last,  0);
        check_eq({tag, "_idle"},      o_idle,  1);
    endtask

    // One grant: request, check grant, stream beats, then drain (or reset at abort_at)
    task automatic run_burst(input logic [3:0] mask, input bit hold, input int mode,
                             input int abort_at, input int drain_cycles);
        int          k;
        int          sent;
        int          cyc;
        bit          v, pv, plast, done, aborted;
        logic [31:0] pdata;
        logic [3:0]  exp_gnt;

        k = rr_pick(mask, model_rr);
        exp_gnt = '0;
        exp_gnt[k] = 1'b1;
        check_eq("idle_before_req", o_idle, 1);
        bus0.req = mask;
        @(negedge clk);
        check_eq("gnt", o_gnt, exp_gnt);
        check_eq("gen_in_valid", o_giv, 1);
        check_eq("gen_seed", o_seed, bus0.seed_bus[k*DW +: DW]);
        check_eq("idle_in_grant", o_idle, 0);
        model_rr = (k + 1) % NREQ;
        if (!hold) bus0.req = '0;
        bus0.gen_busy = 1'b1;
        @(negedge clk);
        check_eq("gnt_drop", o_gnt, 0);
        check_eq("gen_in_valid_drop", o_giv, 0);
        check_eq("out_valid_load", o_valid, 0);

        sent = 0; cyc = 0; pv = 0; plast = 0; done = 0; aborted = 0; pdata = '0;
        for (int guard = 0; guard < 4000 && !done; guard++) begin
            check_eq("out_valid", o_valid, pv);
            check_eq("out_last", o_last, pv && plast);
            if (pv) begin
                check_eq("out_data", o_data, pdata);
                check_eq("out_id", o_id, k);
            end
            if (pv && plast) begin
                done = 1;
            end else if (abort_at != 0 && pv && sent == abort_at) begin
                aborted = 1;
                done = 1;
            end else begin
                v = (sent < cur_len) && beat_on(mode, cyc);
                cyc++;
                bus0.gen_out_valid = v;
                bus0.gen_rand = $urandom;
                pv = v;
                pdata = bus0.gen_rand;
                if (v) sent++;
                plast = v && (sent == cur_len);
                @(negedge clk);
            end
        end
        check_eq("burst_done", done, 1);

        if (aborted) begin
            bus0.gen_out_valid = 1'b1;
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async_rst");
            bus0.gen_out_valid = 1'b0;
            bus0.gen_busy = 1'b0;
            bus0.req = '0;
            model_rr = 0;
            @(negedge clk);
            @(negedge clk);
            check_reset_outputs("held_rst");
            rst_n = 1'b1;
            @(negedge clk);
        end else begin
            for (int i = 0; i < drain_cycles; i++) begin
                bus0.gen_out_valid = 1'($urandom_range(0, 1));
                bus0.gen_rand = $urandom;
                @(negedge clk);
                check_eq("drain_out_valid", o_valid, 0);
                check_eq("drain_idle", o_idle, 0);
            end
            bus0.gen_out_valid = 1'b0;
            bus0.gen_busy = 1'b0;
            @(negedge clk);
            check_eq("idle_after_drain", o_idle, 1);
            check_eq("out_valid_idle", o_valid, 0);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        sel = 1'b0;
        cur_len = 256;
        model_rr = 0;
        rst_n = 1'b0;
        bus0.req = '0;
        bus0.gen_busy = 1'b0;
        bus0.gen_out_valid = 1'b0;
        bus0.gen_rand = '0;
        for (int i = 0; i < NREQ; i++) bus0.seed_bus[i*DW +: DW] = $urandom;
        bus0.seed_bus[0 +: DW] = 32'h1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester, seed 1, continuous beats
        run_burst(4'b0001, 1'b0, MODE_ON, 0, 3);
        // 3-on/5-off generator gaps
        run_burst(4'b0001, 1'b0, MODE_GAP, 0, 2);
        // Reset at beat 100 of requester 1's burst; rr pointer must return to 0
        run_burst(4'b0010, 1'b0, MODE_RAND, 100, 0);
        // All requesters held: 0,1,2,3,0
        for (int i = 0; i < 5; i++) run_burst(4'b1111, 1'b1, MODE_RAND, 0, 2);
        // Serve 1 (rr -> 2), then 0011 must pick 0 before 1
        run_burst(4'b0010, 1'b0, MODE_RAND, 0, 1);
        run_burst(4'b0011, 1'b0, MODE_ON, 0, 1);
        // Zero seed passes through; requester 1 dropped above is not served
        bus0.seed_bus[3*DW +: DW] = 32'h0;
        run_burst(4'b1000, 1'b0, MODE_RAND, 0, 1);
        // BURST_LEN=1 instance, generator busy 10 cycles after the beat
        sel = 1'b1;
        cur_len = 1;
        run_burst(4'b0100, 1'b0, MODE_ON, 0, 10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
